store_align_buffer: RTL and testbench
=====================================

STORE_ALIGN_BUFFER -- requirements
Module: store_align_buffer

Interface
REQ-001 Parameter DATA_W, default 32, memory data width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 4, number of buffered store entries; power of two, >=2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  store request present.
REQ-006 req_ready  output  1  buffer can accept a request.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 doubleword (legal only when DATA_W=64).
REQ-008 req_addr  input  32  store byte address.
REQ-009 req_wdata  input  DATA_W  unaligned store data, value in low-order bits.
REQ-010 flush  input  1  discard all buffered entries.
REQ-011 mem_valid  output  1  head entry presented to memory.
REQ-012 mem_ready  input  1  memory accepts head entry.
REQ-013 mem_addr  output  32  head address with low log2(DATA_W/8) bits cleared.
REQ-014 mem_wdata  output  DATA_W  lane-replicated head data.
REQ-015 mem_wstrb  output  DATA_W/8  head byte enables.
REQ-016 ades  output  1  one-cycle misaligned-store (or illegal size) exception pulse.
REQ-017 ades_badvaddr  output  32  faulting address, held until next ades.
REQ-018 ld_addr  input  32  pending-load address for hazard check.
REQ-019 ld_hit  output  1  combinational: a valid entry shares ld_addr's aligned DATA_W word.
REQ-020 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-021 Request accepted when req_valid && req_ready && !flush; req_ready = (count != DEPTH); no full-bypass, a push is refused when full even if a pop occurs that cycle.
REQ-022 Alignment: byte always aligned; half requires addr[0]=0; word requires addr[1:0]=0; doubleword requires addr[2:0]=0 and DATA_W=64.
REQ-023 Misaligned or illegal-size accepted request is not enqueued; ades pulses high exactly one cycle later; ades_badvaddr loads req_addr at the same edge.
REQ-024 Byte enables: strb = ((1<<(1<<size))-1) << (addr mod DATA_W/8); word with DATA_W=32 gives 4'b1111.
REQ-025 Data: low (8<<size) bits of req_wdata replicated across all DATA_W bits; computed at enqueue, stored per entry with aligned address and strb.
REQ-026 Storage is a circular FIFO with head/tail pointers wrapping modulo DEPTH; order preserved.
REQ-027 Latency: entry enqueued at edge N is visible on mem_* after edge N (mem_valid high in cycle N+1 if buffer was empty).
REQ-028 mem_valid = (count != 0); mem_addr/mem_wdata/mem_wstrb reflect the head entry and stay stable while mem_valid && !mem_ready.
REQ-029 Pop on mem_valid && mem_ready; simultaneous push and pop leave count unchanged.
REQ-030 count: +1 on push only, -1 on pop only, unchanged otherwise.
REQ-031 flush has priority: at the edge, count, head and tail go to 0, any same-cycle push and pop are ignored, no ades raised for a same-cycle request.
REQ-032 ld_hit compares ld_addr[31:log2(DATA_W/8)] against every valid entry; 0 when empty.
REQ-033 Outputs when empty: mem_addr, mem_wdata, mem_wstrb = 0.

Reset
REQ-034 resetn low asynchronously forces count=0, head=tail=0, mem_valid=0, req_ready=1, ades=0, ades_badvaddr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0; entries in flight are discarded.
REQ-035 Entry contents need not be reset; outputs derived from them are gated by valid.

Verification
REQ-036 DATA_W=32: byte store addr 0x1003, wdata 0x000000AB -> next cycle mem_addr 0x1000, mem_wstrb 4'b1000, mem_wdata 0xABABABAB.
REQ-037 DATA_W=32: half store addr 0x2001 -> not enqueued, ades=1 one cycle, ades_badvaddr 0x2001, count stays 0.
REQ-038 DATA_W=64: doubleword addr 0x3008 wdata 0x1122334455667788 -> mem_wstrb 8'hFF, mem_addr 0x3008; word at 0x300C -> mem_wstrb 8'hF0, data replicated.
REQ-039 DEPTH=4, mem_ready=0, five pushes -> four accepted, req_ready=0, count=4; then mem_ready=1 with concurrent push -> entries drain in order, pointers wrap, count correct each cycle.
REQ-040 Two entries at 0x4000 and 0x4010 -> ld_addr 0x4002 gives ld_hit=1, ld_addr 0x4008 gives ld_hit=0 (DATA_W=32); flush with concurrent push -> next cycle count=0, mem_valid=0, ld_hit=0.
REQ-041 resetn asserted mid-drain with count=3 -> immediately mem_valid=0, count=0, req_ready=1.

Source files
------------

// File: rtl/store_align_buffer_if.sv
`timescale 1ns/1ps
// store_align_buffer_if
//   Bundles the two handshake channels of the store alignment buffer.
//   req_*  : store requests from the pipeline (size, byte address, raw data)
//   mem_*  : aligned, lane-replicated, byte-enabled writes toward memory
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid && ready are both high. The producer holds valid and
// its payload stable until that edge. The consumer may drive ready
// independently of valid. Neither side revokes valid before the transfer
// completes, except for an explicit flush of the buffer.
//
// Modports:
//   slave  : the buffer's view (consumes req_*, produces mem_*)
//   master : the environment's view (produces req_*, consumes mem_*)
interface store_align_buffer_if #(
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_size;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [31:0]           mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;

  modport slave (
    input  req_valid, req_size, req_addr, req_wdata,
    output req_ready,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready
  );

  modport master (
    output req_valid, req_size, req_addr, req_wdata,
    input  req_ready,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready
  );
endinterface

// File: rtl/store_align_buffer.sv
`timescale 1ns/1ps
// store_align_buffer
//   Accepts unaligned-format stores (value in low bits, byte address,
//   size), checks natural alignment, converts legal stores into an
//   aligned memory write (word address, replicated data, byte strobes)
//   and queues them in a small circular FIFO that drains to memory.
//   Misaligned or illegal-size stores raise a one-cycle ades pulse and
//   latch the faulting address instead of being queued.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   resetn        asynchronous active-low reset
//   bus           store_align_buffer_if.slave: req_* in, mem_* out
//   flush         discard all buffered entries (wins over push/pop)
//   ades          one-cycle misaligned-store exception pulse
//   ades_badvaddr faulting address of the most recent ades
//   ld_addr       pending load address for store->load hazard check
//   ld_hit        a valid entry covers ld_addr's aligned memory word
//   count         number of valid entries (0..DEPTH)
module store_align_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  store_align_buffer_if.slave    bus,
  input  logic                   flush,
  output logic                   ades,
  output logic [31:0]            ades_badvaddr,
  input  logic [31:0]            ld_addr,
  output logic                   ld_hit,
  output logic [$clog2(DEPTH):0] count
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage; contents are not reset, validity is tracked separately.
  logic [31:0]       ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [BYTES-1:0]  ent_strb [DEPTH];
  logic [DEPTH-1:0]  ent_valid;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;

  logic              misalign;
  logic [7:0]        base_strb;
  logic [15:0]       shifted_strb;
  logic [BYTES-1:0]  req_strb;
  logic [OFF_W-1:0]  lane_mask;
  logic [OFF_W-1:0]  lane;
  logic [DATA_W-1:0] req_data;
  logic [31:0]       req_aligned_addr;

  logic              accept;
  logic              push;
  logic              pop;

  // ------------------------------------------------------------------
  // Alignment check. Doubleword is only legal on a 64-bit memory bus.
  // ------------------------------------------------------------------
  always_comb begin
    misalign = 1'b0;
    case (bus.req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = bus.req_addr[0];
      2'b10:   misalign = |bus.req_addr[1:0];
      2'b11:   misalign = (DATA_W != 64) || (|bus.req_addr[2:0]);
      default: misalign = 1'b1;
    endcase
  end

  // ------------------------------------------------------------------
  // Byte strobes: a run of (1<<size) ones shifted to the byte offset.
  // The 16-bit intermediate keeps the shift from losing bits before the
  // result is trimmed to the bus width; legal stores never spill past it.
  // ------------------------------------------------------------------
  always_comb begin
    base_strb = 8'h00;
    case (bus.req_size)
      2'b00:   base_strb = 8'h01;
      2'b01:   base_strb = 8'h03;
      2'b10:   base_strb = 8'h0F;
      2'b11:   base_strb = 8'hFF;
      default: base_strb = 8'h00;
    endcase
    shifted_strb = {8'h00, base_strb} << bus.req_addr[OFF_W-1:0];
    req_strb     = shifted_strb[BYTES-1:0];
  end

  // ------------------------------------------------------------------
  // Data replication: output byte i takes source byte (i mod size_bytes),
  // which repeats the low-order store value across every lane.
  // ------------------------------------------------------------------
  always_comb begin
    lane_mask = '0;
    case (bus.req_size)
      2'b00:   lane_mask = '0;
      2'b01:   lane_mask = OFF_W'(1);
      2'b10:   lane_mask = OFF_W'(3);
      2'b11:   lane_mask = OFF_W'(7);
      default: lane_mask = '0;
    endcase
    lane     = '0;
    req_data = '0;
    for (int i = 0; i < BYTES; i++) begin
      lane = OFF_W'(i) & lane_mask;
      req_data[i*8 +: 8] = bus.req_wdata[{lane, 3'b000} +: 8];
    end
  end

  assign req_aligned_addr = {bus.req_addr[31:OFF_W], {OFF_W{1'b0}}};

  // ------------------------------------------------------------------
  // Handshake control. A full buffer refuses pushes even when a pop is
  // happening in the same cycle (no full bypass).
  // ------------------------------------------------------------------
  assign bus.req_ready = (cnt != CNT_W'(DEPTH));
  assign bus.mem_valid = (cnt != '0);

  assign accept = bus.req_valid && bus.req_ready && !flush;
  assign push   = accept && !misalign;
  assign pop    = bus.mem_valid && bus.mem_ready && !flush;

  // ------------------------------------------------------------------
  // Pointers, count, validity and exception register.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head          <= '0;
      tail          <= '0;
      cnt           <= '0;
      ent_valid     <= '0;
      ades          <= 1'b0;
      ades_badvaddr <= '0;
    end else if (flush) begin
      // Flush wins over any same-cycle request or drain.
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      ent_valid <= '0;
      ades      <= 1'b0;
    end else begin
      ades <= accept && misalign;
      if (accept && misalign) begin
        ades_badvaddr <= bus.req_addr;
      end

      if (push) begin
        tail            <= tail + PTR_W'(1);
        ent_valid[tail] <= 1'b1;
      end
      // Push and pop never target the same slot: a push needs a
      // non-full buffer and a pop a non-empty one, so head==tail
      // cannot occur with both active.
      if (pop) begin
        head            <= head + PTR_W'(1);
        ent_valid[head] <= 1'b0;
      end

      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage: written on push only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= req_aligned_addr;
      ent_data[tail] <= req_data;
      ent_strb[tail] <= req_strb;
    end
  end

  // ------------------------------------------------------------------
  // Head presentation, gated so an empty buffer shows all zeros.
  // ------------------------------------------------------------------
  assign bus.mem_addr  = bus.mem_valid ? ent_addr[head] : '0;
  assign bus.mem_wdata = bus.mem_valid ? ent_data[head] : '0;
  assign bus.mem_wstrb = bus.mem_valid ? ent_strb[head] : '0;

  // ------------------------------------------------------------------
  // Load hazard: any valid entry in the same aligned memory word.
  // ------------------------------------------------------------------
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i][31:OFF_W] == ld_addr[31:OFF_W])) begin
        ld_hit = 1'b1;
      end
    end
  end

  assign count = cnt;

endmodule

// File: tb/tb_store_align_buffer.sv
`timescale 1ns/1ps
// Bench for store_align_buffer: one 32-bit and one 64-bit instance.
module tb_store_align_buffer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  store_align_buffer_if #(.DATA_W(32)) bus32 ();
  store_align_buffer_if #(.DATA_W(64)) bus64 ();

  logic        flush32, flush64;
  logic        ades32, ades64;
  logic [31:0] badv32, badv64;
  logic [31:0] ld32, ld64;
  logic        hit32, hit64;
  logic [2:0]  count32, count64;

  store_align_buffer #(.DATA_W(32), .DEPTH(4)) dut32 (
    .clk(clk), .resetn(resetn), .bus(bus32.slave), .flush(flush32),
    .ades(ades32), .ades_badvaddr(badv32), .ld_addr(ld32),
    .ld_hit(hit32), .count(count32)
  );

  store_align_buffer #(.DATA_W(64), .DEPTH(4)) dut64 (
    .clk(clk), .resetn(resetn), .bus(bus64.slave), .flush(flush64),
    .ades(ades64), .ades_badvaddr(badv64), .ld_addr(ld64),
    .ld_hit(hit64), .count(count64)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_bad32;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is64;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;
    bit          exp_ades;
    logic [31:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_data;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  // ---------------- drivers ----------------
  task automatic idle_all();
    bus32.req_valid = 1'b0; bus32.req_size = 2'b00; bus32.req_addr = '0;
    bus32.req_wdata = '0;   bus32.mem_ready = 1'b0;
    bus64.req_valid = 1'b0; bus64.req_size = 2'b00; bus64.req_addr = '0;
    bus64.req_wdata = '0;   bus64.mem_ready = 1'b0;
    flush32 = 1'b0; flush64 = 1'b0; ld32 = '0; ld64 = '0;
  endtask

  // One table vector: drive at a negedge, the store is accepted at the
  // next posedge, visible on the following negedge, popped one cycle later.
  task automatic apply_vec(input int idx, input vec_t v);
    logic        a_ades, a_valid;
    logic [31:0] a_badv, a_addr;
    logic [7:0]  a_strb;
    logic [63:0] a_data;
    logic [2:0]  a_cnt;
    @(negedge clk);
    bus32.mem_ready = 1'b1;
    bus64.mem_ready = 1'b1;
    if (v.is64) begin
      bus64.req_valid = 1'b1; bus64.req_size = v.size;
      bus64.req_addr  = v.addr; bus64.req_wdata = v.wdata;
    end else begin
      bus32.req_valid = 1'b1; bus32.req_size = v.size;
      bus32.req_addr  = v.addr; bus32.req_wdata = v.wdata[31:0];
    end
    @(negedge clk);
    bus32.req_valid = 1'b0;
    bus64.req_valid = 1'b0;
    a_ades  = v.is64 ? ades64 : ades32;
    a_badv  = v.is64 ? badv64 : badv32;
    a_valid = v.is64 ? bus64.mem_valid : bus32.mem_valid;
    a_addr  = v.is64 ? bus64.mem_addr  : bus32.mem_addr;
    a_strb  = v.is64 ? bus64.mem_wstrb : {4'h0, bus32.mem_wstrb};
    a_data  = v.is64 ? bus64.mem_wdata : {32'h0, bus32.mem_wdata};
    a_cnt   = v.is64 ? count64 : count32;
    check($sformatf("v%0d ades", idx), 64'(a_ades), 64'(v.exp_ades));
    if (v.exp_ades) begin
      check($sformatf("v%0d badvaddr", idx), 64'(a_badv), 64'(v.addr));
      check($sformatf("v%0d count", idx), 64'(a_cnt), 64'd0);
      check($sformatf("v%0d mem_valid", idx), 64'(a_valid), 64'd0);
      if (!v.is64) last_bad32 = v.addr;
    end else begin
      check($sformatf("v%0d mem_valid", idx), 64'(a_valid), 64'd1);
      check($sformatf("v%0d mem_addr", idx), 64'(a_addr), 64'(v.exp_addr));
      check($sformatf("v%0d mem_wstrb", idx), 64'(a_strb), 64'(v.exp_strb));
      check($sformatf("v%0d mem_wdata", idx), a_data, v.exp_data);
    end
    @(negedge clk);
    a_ades = v.is64 ? ades64 : ades32;
    a_cnt  = v.is64 ? count64 : count32;
    check($sformatf("v%0d ades_pulse_end", idx), 64'(a_ades), 64'd0);
    check($sformatf("v%0d drained", idx), 64'(a_cnt), 64'd0);
  endtask

  // One cycle on the 32-bit instance with a byte store; the queue model
  // predicts the FIFO. Called at a negedge, returns at the next negedge.
  task automatic step(input logic valid, input logic [31:0] addr, input logic ready);
    bit          push, pop;
    logic [31:0] h;
    bus32.req_valid = valid;
    bus32.req_size  = 2'b00;
    bus32.req_addr  = addr;
    bus32.req_wdata = {24'h0, addr[15:8]};
    bus32.mem_ready = ready;
    push = valid && (exp_q.size() != 4);
    pop  = ready && (exp_q.size() != 0);
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(addr);
    @(posedge clk);
    @(negedge clk);
    bus32.req_valid = 1'b0;
    check("seq count", 64'(count32), 64'(exp_q.size()));
    check("seq req_ready", 64'(bus32.req_ready), 64'(exp_q.size() != 4));
    check("seq mem_valid", 64'(bus32.mem_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("seq mem_addr", 64'(bus32.mem_addr), 64'({h[31:2], 2'b00}));
      check("seq mem_wstrb", 64'(bus32.mem_wstrb), 64'(4'b0001 << h[1:0]));
      check("seq mem_wdata", 64'(bus32.mem_wdata), 64'({4{h[15:8]}}));
    end else begin
      check("seq mem_addr empty", 64'(bus32.mem_addr), 64'd0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{1'b0, 2'd0, 32'h1003, 64'h0000_00AB,            1'b0, 32'h1000, 8'h08, 64'hABAB_ABAB};
    vecs[1]  = '{1'b0, 2'd1, 32'h2001, 64'h0000_1234,            1'b1, 32'h0,    8'h00, 64'h0};
    vecs[2]  = '{1'b0, 2'd1, 32'h2002, 64'h0000_1234,            1'b0, 32'h2000, 8'h0C, 64'h1234_1234};
    vecs[3]  = '{1'b0, 2'd2, 32'h2004, 64'hDEAD_BEEF,            1'b0, 32'h2004, 8'h0F, 64'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 2'd2, 32'h2006, 64'h1111_2222,            1'b1, 32'h0,    8'h00, 64'h0};
    vecs[5]  = '{1'b0, 2'd0, 32'h5000, 64'hFFFF_FF5A,            1'b0, 32'h5000, 8'h01, 64'h5A5A_5A5A};
    vecs[6]  = '{1'b0, 2'd3, 32'h3000, 64'h0,                    1'b1, 32'h0,    8'h00, 64'h0};
    vecs[7]  = '{1'b0, 2'd1, 32'h7006, 64'hAAAA_C3D2,            1'b0, 32'h7004, 8'h0C, 64'hC3D2_C3D2};
    vecs[8]  = '{1'b1, 2'd3, 32'h3008, 64'h1122_3344_5566_7788,  1'b0, 32'h3008, 8'hFF, 64'h1122_3344_5566_7788};
    vecs[9]  = '{1'b1, 2'd2, 32'h300C, 64'hFFFF_FFFF_AABB_CCDD,  1'b0, 32'h3008, 8'hF0, 64'hAABB_CCDD_AABB_CCDD};
    vecs[10] = '{1'b1, 2'd3, 32'h3004, 64'h1,                    1'b1, 32'h0,    8'h00, 64'h0};
    vecs[11] = '{1'b1, 2'd0, 32'h3006, 64'h7E,                   1'b0, 32'h3000, 8'h40, 64'h7E7E_7E7E_7E7E_7E7E};
    vecs[12] = '{1'b1, 2'd1, 32'h300A, 64'hBEEF,                 1'b0, 32'h3008, 8'h0C, 64'hBEEF_BEEF_BEEF_BEEF};

    last_bad32 = '0;
    idle_all();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst count", 64'(count32), 64'd0);
    check("rst mem_valid", 64'(bus32.mem_valid), 64'd0);
    check("rst req_ready", 64'(bus32.req_ready), 64'd1);
    check("rst ades", 64'(ades32), 64'd0);
    check("rst badvaddr", 64'(badv32), 64'd0);
    check("rst mem_addr", 64'(bus32.mem_addr), 64'd0);
    check("rst mem_wdata", 64'(bus32.mem_wdata), 64'd0);
    check("rst mem_wstrb", 64'(bus32.mem_wstrb), 64'd0);
    check("rst count64", 64'(count64), 64'd0);
    check("rst mem_wstrb64", 64'(bus64.mem_wstrb), 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) apply_vec(i, vecs[i]);

    // Fill with memory stalled: four accepted, fifth refused, head stable.
    exp_q.delete();
    @(negedge clk);
    step(1'b1, 32'h0100, 1'b0);
    step(1'b1, 32'h0201, 1'b0);
    step(1'b1, 32'h0302, 1'b0);
    step(1'b1, 32'h0403, 1'b0);
    step(1'b1, 32'h0500, 1'b0);
    // Drain with concurrent pushes; pointers wrap past DEPTH.
    for (int k = 0; k < 7; k++) begin
      step(k < 3, 32'h0600 + 32'(k) * 32'h0101, 1'b1);
    end

    // Load hazard and flush.
    step(1'b1, 32'h4000, 1'b0);
    step(1'b1, 32'h4010, 1'b0);
    ld32 = 32'h4002; #1;
    check("ld_hit 0x4002", 64'(hit32), 64'd1);
    ld32 = 32'h4008; #1;
    check("ld_hit 0x4008", 64'(hit32), 64'd0);
    ld32 = 32'h4013; #1;
    check("ld_hit 0x4013", 64'(hit32), 64'd1);
    flush32 = 1'b1;
    bus32.req_valid = 1'b1; bus32.req_size = 2'b00; bus32.req_addr = 32'h4020;
    ld32 = 32'h4020;
    @(posedge clk); @(negedge clk);
    flush32 = 1'b0; bus32.req_valid = 1'b0;
    exp_q.delete();
    check("flush count", 64'(count32), 64'd0);
    check("flush mem_valid", 64'(bus32.mem_valid), 64'd0);
    check("flush ld_hit", 64'(hit32), 64'd0);
    check("flush mem_addr", 64'(bus32.mem_addr), 64'd0);
    // Misaligned request under flush raises nothing.
    flush32 = 1'b1;
    bus32.req_valid = 1'b1; bus32.req_size = 2'b01; bus32.req_addr = 32'h4021;
    @(posedge clk); @(negedge clk);
    flush32 = 1'b0; bus32.req_valid = 1'b0;
    check("flush no ades", 64'(ades32), 64'd0);
    check("flush badvaddr kept", 64'(badv32), 64'(last_bad32));
    check("flush no enqueue", 64'(count32), 64'd0);

    // Asynchronous reset mid-drain.
    step(1'b1, 32'h0900, 1'b0);
    step(1'b1, 32'h0A01, 1'b0);
    step(1'b1, 32'h0B02, 1'b0);
    step(1'b1, 32'h0C03, 1'b0);
    step(1'b0, 32'h0000, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("async rst count", 64'(count32), 64'd0);
    check("async rst mem_valid", 64'(bus32.mem_valid), 64'd0);
    check("async rst req_ready", 64'(bus32.req_ready), 64'd1);
    check("async rst badvaddr", 64'(badv32), 64'd0);
    check("async rst mem_wstrb", 64'(bus32.mem_wstrb), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    step(1'b1, 32'h0D02, 1'b1);
    step(1'b0, 32'h0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
